// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the NOP instruction word and default widths.
package fetch_stage_pkg;

    localparam int DEF_PC_W   = 12;
    localparam int DEF_INSN_W = 32;

    // FSM state encodings
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Bubble instruction placed in F/D whenever it holds no real instruction
    localparam logic [31:0] NOP_INSN = 32'd0;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction hold buffer. Captures the ROM word that arrives
// while decode is stalled, hands it back on stall release, and is dropped
// on reset or redirect.
module fetch_hold_buf #(
    parameter int INSN_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              capture,
    input  logic              consume,
    input  logic [INSN_W-1:0] data_in,
    output logic [INSN_W-1:0] insn,
    output logic              valid
);

    // Valid bit: flush beats capture beats consume
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

    // Payload only needs loading on capture; valid qualifies it
    always_ff @(posedge clock) begin
        if (capture) begin
            insn <= data_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register and instruction-fetch stage. Drives a synchronous instruction
// ROM from a registered PC, tracks the in-flight fetch, and loads the F/D
// latch. Decode stalls are absorbed by a one-entry hold buffer; redirects
// flush everything in flight.
// Optional build macro FETCH_STATS_EN adds stall_cycles / redirect_count
// saturating counters as extra outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INSN_W   = DEF_INSN_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    input  logic [PC_W-1:0]   next_pc,
    input  logic              redirect,
    input  logic              stall,
    output logic [PC_W-1:0]   fd_pc,
    output logic [INSN_W-1:0] fd_insn,
    output logic              fd_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       redirect_count
`endif
);

    localparam logic [INSN_W-1:0] NOP = INSN_W'(NOP_INSN);

    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   f_pc_q;
    logic              f_valid_q;
    logic [0:0]        state_q;
    logic [INSN_W-1:0] hold_insn;
    logic              hold_valid;
    logic              hold_capture;
    logic              hold_consume;

    // The ROM address is always the registered PC, never a combinational mux
    assign imem_addr = pc_q;

    // Modulo-2^PC_W increment; wraps naturally at the top of the address space
    assign pc_inc = pc_q + PC_W'(1);

    // Buffer control: capture the arriving word on entry to HOLD, return it on release
    assign hold_capture = !redirect && (state_q == ST_RUN) && stall && f_valid_q;
    assign hold_consume = !redirect && (state_q == ST_HOLD) && !stall;

    fetch_hold_buf #(
        .INSN_W (INSN_W)
    ) u_hold_buf (
        .clock   (clock),
        .reset   (reset),
        .flush   (redirect),
        .capture (hold_capture),
        .consume (hold_consume),
        .data_in (imem_data),
        .insn    (hold_insn),
        .valid   (hold_valid)
    );

    // PC / in-flight fetch / F/D latch / RUN-HOLD FSM; reset > redirect > stall
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            f_pc_q    <= RESET_PC;
            f_valid_q <= 1'b0;
            fd_pc     <= '0;
            fd_insn   <= NOP;
            fd_valid  <= 1'b0;
            state_q   <= ST_RUN;
        end else if (redirect) begin
            pc_q      <= next_pc;
            f_valid_q <= 1'b0;
            fd_insn   <= NOP;
            fd_valid  <= 1'b0;
            state_q   <= ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (!stall) begin
                fd_pc     <= f_pc_q;
                fd_insn   <= f_valid_q ? imem_data : NOP;
                fd_valid  <= f_valid_q;
                f_pc_q    <= pc_q;
                f_valid_q <= 1'b1;
                pc_q      <= pc_inc;
            end else begin
                state_q   <= ST_HOLD;
            end
        end else begin
            // HOLD: the word for f_pc_q sits in the hold buffer, the ROM keeps
            // re-reading pc_q so its data is ready the cycle after release
            if (!stall) begin
                fd_pc     <= f_pc_q;
                fd_insn   <= hold_valid ? hold_insn : NOP;
                fd_valid  <= hold_valid;
                f_pc_q    <= pc_q;
                f_valid_q <= 1'b1;
                pc_q      <= pc_inc;
                state_q   <= ST_RUN;
            end
        end
    end

`ifdef FETCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters; a redirect cycle is not counted as a stall
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (stall && !redirect) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (redirect) begin
                redirect_count <= sat_inc(redirect_count);
            end
        end
    end
`endif

endmodule
